operand_load_sequencer: RTL and testbench
=========================================

// Module: operand_load_sequencer
// PURPOSE
//  FSM that sequences the load enables of the n-bit operand/opcode/result registers
//  (synchronous reset, load-enable registers) in the switch-entry calculator datapath.
//  Each user "enter" press advances A -> B -> OPCODE. The block then strobes the result register.
//  The result stays shown until the next press, a clear, or an optional timeout.
//  The block holds no datapath bits: it drives only the load strobes and status.
// PARAMETERS
//  TIMEOUT  32'd500_000_000  cycles spent in SHOW before auto-return to WAIT_A; 0 = never
// PORTS
//  clk           in   1  system clock, all logic on posedge
//  rst           in   1  synchronous, active-high reset
//  enter         in   1  debounced enter button, level; the block edge-detects it internally
//  clear         in   1  debounced clear button, level; synchronous abort to WAIT_A
//  load_a        out  1  one-cycle load strobe, operand A register
//  load_b        out  1  one-cycle load strobe, operand B register
//  load_op       out  1  one-cycle load strobe, opcode register
//  load_res      out  1  one-cycle load strobe, result register
//  state_o       out  3  current state code, drives display mux/LEDs
//  result_valid  out  1  high while in SHOW
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=WAIT_A, all strobes 0, result_valid 0, timer 0, enter_q 1.
//    enter_q resets to 1, so an enter held through reset is ignored until it is released and pressed again.
//  - Priority at each posedge: rst > clear > timeout/enter.
//  - Edge detect: enter_q <= enter every cycle, including during clear.
//    enter_rise = enter & ~enter_q. Holding enter high yields exactly one rise.
//  - States (state_o code):
//      WAIT_A(0)  rise -> WAIT_B; load_a=1 next cycle
//      WAIT_B(1)  rise -> WAIT_OP; load_b=1 next cycle
//      WAIT_OP(2) rise -> CALC; load_op=1 next cycle
//      CALC(3)    unconditional -> SHOW; load_res=1 next cycle; enter ignored
//      SHOW(4)    rise or timer==TIMEOUT-1 (TIMEOUT!=0) -> WAIT_A; no strobe
//      codes 5-7  illegal; next state WAIT_A, no strobe
//  - Strobes are registered. Each strobe is high for exactly the one cycle after the posedge
//    that performs its transition. This places load_res exactly 1 cycle after load_op, so the
//    ALU sees the registered opcode. The registers capture on the posedge that ends the strobe cycle.
//  - At most one strobe is high in any cycle. Strobes are 0 in every cycle not listed above.
//  - result_valid = (state==SHOW), registered with the state.
//  - Timer: cleared on entry to SHOW and in every other state. It increments by 1 per cycle in SHOW.
//    It is wide enough for TIMEOUT-1 and never wraps. A rise in the expiry cycle gives the same result: WAIT_A.
//  - clear=1: next state WAIT_A, all strobes 0, timer 0, regardless of enter. A rise in that cycle is consumed.
//  - rst or clear while in CALC: load_res is NOT asserted.
//  - The block does not clear the datapath registers. Their own rst does that.
// TESTING
//  1 rst 2 cycles, enter=0 -> state_o=0, all strobes 0, result_valid=0.
//  2 Three presses (enter high 5, low 5 cycles each) -> load_a, load_b, load_op are each one
//    1-cycle pulse. load_res pulses on the cycle right after load_op.
//    state_o steps 0,1,2,3,4; result_valid=1.
//  3 enter held high 20 cycles in WAIT_A -> exactly one load_a pulse; state_o=1 throughout.
//  4 TIMEOUT=10, reach SHOW, enter=0 -> state_o returns to 0 exactly 10 cycles after entering SHOW.
//    result_valid falls with it; no strobes. With TIMEOUT=0, SHOW holds for 1000 cycles.
//  5 In WAIT_OP, clear=1 in the same cycle as an enter rise -> state_o=0, no load_op.
//    A following press gives load_a.
//  6 enter=1 across rst deassertion -> no transition. After release and a re-press -> load_a.
//    rst pulsed while in CALC -> load_res stays 0, state_o=0.

Source files
------------

// File: rtl/operand_load_sequencer.sv
// Sequences the load strobes for the switch-entry calculator's A, B, opcode and result registers.
// Holds no datapath bits; only the one-cycle strobes, the state code and the result_valid flag.
module operand_load_sequencer #(
  parameter logic [31:0] TIMEOUT = 32'd500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       clear,
  output logic       load_a,
  output logic       load_b,
  output logic       load_op,
  output logic       load_res,
  output logic [2:0] state_o,
  output logic       result_valid
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  // Timer only needs to reach TIMEOUT-1, so it never has to wrap
  localparam int          TW   = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] LAST = (TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            enter_q;
  logic            enter_rise;
  logic            expired;

  assign enter_rise = enter & ~enter_q;
  assign expired    = (TIMEOUT != 32'd0) && (timer == LAST[TW-1:0]);
  assign state_o    = state;

  // enter_q resets high so a button held through reset is not taken as a press
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_A;
      timer        <= '0;
      enter_q      <= 1'b1;
      load_a       <= 1'b0;
      load_b       <= 1'b0;
      load_op      <= 1'b0;
      load_res     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      enter_q      <= enter;
      timer        <= '0;
      load_a       <= 1'b0;
      load_b       <= 1'b0;
      load_op      <= 1'b0;
      load_res     <= 1'b0;
      result_valid <= 1'b0;
      if (clear) begin
        state <= WAIT_A;
      end else begin
        case (state)
          WAIT_A: begin
            if (enter_rise) begin
              state  <= WAIT_B;
              load_a <= 1'b1;
            end
          end
          WAIT_B: begin
            if (enter_rise) begin
              state  <= WAIT_OP;
              load_b <= 1'b1;
            end
          end
          WAIT_OP: begin
            if (enter_rise) begin
              state   <= CALC;
              load_op <= 1'b1;
            end
          end
          CALC: begin
            state        <= SHOW;
            load_res     <= 1'b1;
            result_valid <= 1'b1;
          end
          SHOW: begin
            if (enter_rise || expired) begin
              state <= WAIT_A;
            end else begin
              result_valid <= 1'b1;
              if (TIMEOUT != 32'd0) timer <= timer + TW'(1);
            end
          end
          default: state <= WAIT_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_load_sequencer.sv
// Scoreboard bench for operand_load_sequencer: strobes expected per cycle are queued when enter is driven.
// A second instance with TIMEOUT=0 shares the inputs to show SHOW holding indefinitely.
module tb_operand_load_sequencer;

  logic       clk = 1'b0;
  logic       rst, enter, clear;
  logic       load_a, load_b, load_op, load_res, result_valid;
  logic [2:0] state_o;
  logic       load_a0, load_b0, load_op0, load_res0, result_valid0;
  logic [2:0] state_o0;

  typedef struct {
    int         due;
    logic [3:0] code;
  } exp_t;

  localparam logic [3:0] S_A = 4'b0001, S_B = 4'b0010, S_OP = 4'b0100, S_RES = 4'b1000;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  operand_load_sequencer #(.TIMEOUT(32'd10)) dut (
    .clk(clk), .rst(rst), .enter(enter), .clear(clear),
    .load_a(load_a), .load_b(load_b), .load_op(load_op), .load_res(load_res),
    .state_o(state_o), .result_valid(result_valid)
  );

  operand_load_sequencer #(.TIMEOUT(32'd0)) dut0 (
    .clk(clk), .rst(rst), .enter(enter), .clear(clear),
    .load_a(load_a0), .load_b(load_b0), .load_op(load_op0), .load_res(load_res0),
    .state_o(state_o0), .result_valid(result_valid0)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One cycle: sample at negedge and compare the strobe vector with the scoreboard
  task automatic step(input int n);
    logic [3:0] want;
    exp_t       e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        want = 4'b0000;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e    = exp_q.pop_front();
          want = e.code;
        end
        checkOutput("strobes", 32'({load_res, load_op, load_b, load_a}), 32'(want));
      end
    end
  endtask

  task automatic expectStrobe(input int delay, input logic [3:0] code);
    exp_t e;
    e.due  = cyc + delay;
    e.code = code;
    exp_q.push_back(e);
  endtask

  // A press of hi cycles high then lo cycles low, with up to two strobes expected after the rise
  task automatic applyStimulus(input int hi, input int lo, input logic [3:0] s1, input logic [3:0] s2);
    if (s1 != 4'b0) expectStrobe(1, s1);
    if (s2 != 4'b0) expectStrobe(2, s2);
    enter = 1'b1;
    step(hi);
    enter = 1'b0;
    step(lo);
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1; enter = 1'b0; clear = 1'b0;
    step(2);
    checkOutput("reset_state", 32'(state_o), 32'd0);
    checkOutput("reset_strobes", 32'({load_res, load_op, load_b, load_a}), 32'd0);
    checkOutput("reset_valid", 32'(result_valid), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    step(2);

    // Full sequence A, B, OP with state stepping through CALC into SHOW
    applyStimulus(5, 5, S_A, 4'b0);
    checkOutput("state_after_a", 32'(state_o), 32'd1);
    applyStimulus(5, 5, S_B, 4'b0);
    checkOutput("state_after_b", 32'(state_o), 32'd2);
    expectStrobe(1, S_OP);
    expectStrobe(2, S_RES);
    enter = 1'b1;
    step(1);
    checkOutput("state_calc", 32'(state_o), 32'd3);
    step(1);
    checkOutput("state_show", 32'(state_o), 32'd4);
    checkOutput("valid_show", 32'(result_valid), 32'd1);
    step(3);
    enter = 1'b0;

    // Timeout of 10: SHOW first seen at sample 2 after the rise, WAIT_A at sample 12
    step(6);
    checkOutput("show_before_timeout", 32'(state_o), 32'd4);
    checkOutput("valid_before_timeout", 32'(result_valid), 32'd1);
    step(1);
    checkOutput("state_after_timeout", 32'(state_o), 32'd0);
    checkOutput("valid_after_timeout", 32'(result_valid), 32'd0);
    checkOutput("no_timeout_state", 32'(state_o0), 32'd4);
    step(3);

    // Enter held for 20 cycles gives one load_a only
    expectStrobe(1, S_A);
    enter = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      checkOutput("held_state", 32'(state_o), 32'd1);
    end
    enter = 1'b0;
    step(3);

    // Clear coinciding with a rise in WAIT_OP aborts and consumes the rise
    applyStimulus(5, 5, S_B, 4'b0);
    checkOutput("state_wait_op", 32'(state_o), 32'd2);
    clear = 1'b1;
    enter = 1'b1;
    step(1);
    checkOutput("state_after_clear", 32'(state_o), 32'd0);
    clear = 1'b0;
    step(3);
    checkOutput("clear_rise_consumed", 32'(state_o), 32'd0);
    enter = 1'b0;
    step(2);
    applyStimulus(5, 5, S_A, 4'b0);
    checkOutput("press_after_clear", 32'(state_o), 32'd1);

    // Enter held across reset release is ignored until re-pressed
    rst = 1'b1;
    enter = 1'b1;
    step(2);
    rst = 1'b0;
    step(4);
    checkOutput("held_through_reset", 32'(state_o), 32'd0);
    enter = 1'b0;
    step(2);
    applyStimulus(5, 5, S_A, 4'b0);
    checkOutput("press_after_reset", 32'(state_o), 32'd1);

    // Reset in CALC suppresses load_res
    applyStimulus(5, 5, S_B, 4'b0);
    expectStrobe(1, S_OP);
    enter = 1'b1;
    step(1);
    checkOutput("state_calc_2", 32'(state_o), 32'd3);
    rst = 1'b1;
    step(1);
    checkOutput("calc_reset_load_res", 32'(load_res), 32'd0);
    checkOutput("calc_reset_state", 32'(state_o), 32'd0);
    rst = 1'b0;
    enter = 1'b0;
    step(3);

    // TIMEOUT=0 instance stays in SHOW for 1000 cycles
    applyStimulus(5, 5, S_A, 4'b0);
    applyStimulus(5, 5, S_B, 4'b0);
    applyStimulus(5, 5, S_OP, S_RES);
    step(1000);
    checkOutput("no_timeout_hold_state", 32'(state_o0), 32'd4);
    checkOutput("no_timeout_hold_valid", 32'(result_valid0), 32'd1);
    checkOutput("timeout_dut_idle", 32'(state_o), 32'd0);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
